divider: RTL and testbench



---
 rtl/divider_pkg.sv | 15 +
 rtl/divider_datapath.sv | 58 +++++
 rtl/divider.sv | 81 ++++++++
 tb/tb_divider.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divider_state_t;

    // Iteration counter width: must be able to hold 0..n.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divider_datapath.sv
// Restoring-divider datapath: partial remainder A, dividend/quotient Q, latched divisor M.
module divider_datapath #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         do_init,
    input  logic         do_shift,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    logic [N-1:0] a_q;
    logic [N-1:0] q_q;
    logic [N-1:0] m_q;
    logic         dbz_q;

    logic [N:0]   p_c;
    logic [N:0]   diff_c;
    logic         fits_c;

    // Trial subtract in N+1 bits; the difference always fits in N bits when it is kept.
    always_comb begin
        p_c    = {a_q, q_q[N-1]};
        diff_c = p_c - {1'b0, m_q};
        fits_c = (p_c >= {1'b0, m_q});
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            dbz_q <= 1'b0;
        end else if (do_init) begin
            a_q   <= '0;
            q_q   <= dividend;
            m_q   <= divisor;
            dbz_q <= (divisor == '0);
        end else if (do_shift) begin
            if (fits_c) begin
                a_q <= diff_c[N-1:0];
                q_q <= {q_q[N-2:0], 1'b1};
            end else begin
                a_q <= p_c[N-1:0];
                q_q <= {q_q[N-2:0], 1'b0};
            end
        end
    end

    assign quotient    = q_q;
    assign remainder   = a_q;
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/divider.sv
// Sequential unsigned divider: start/busy/done control around a one-bit-per-clock datapath.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned   CW   = count_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    divider_state_t  state;
    logic [CW-1:0]   count;
    logic            do_init_c;
    logic            do_shift_c;

    assign do_init_c  = (state == IDLE) && start;
    assign do_shift_c = (state == RUN);

    // Control FSM; busy and done are registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    divider_datapath #(
        .N(N)
    ) u_datapath (
        .clock      (clock),
        .reset      (reset),
        .do_init    (do_init_c),
        .do_shift   (do_shift_c),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

endmodule

// File: tb/tb_divider.sv
// Directed and table-driven checks of the divider at N=4 and N=8.
module tb_divider;

    logic       clock;
    logic       reset;

    logic       start4;
    logic [3:0] dividend4;
    logic [3:0] divisor4;
    logic       busy4;
    logic       done4;
    logic [3:0] quot4;
    logic [3:0] rem4;
    logic       dbz4;

    logic       start8;
    logic [7:0] dividend8;
    logic [7:0] divisor8;
    logic       busy8;
    logic       done8;
    logic [7:0] quot8;
    logic [7:0] rem8;
    logic       dbz8;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[7];

    divider #(.N(4)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .start      (start4),
        .dividend   (dividend4),
        .divisor    (divisor4),
        .busy       (busy4),
        .done       (done4),
        .quotient   (quot4),
        .remainder  (rem4),
        .div_by_zero(dbz4)
    );

    divider #(.N(8)) dut8 (
        .clock      (clock),
        .reset      (reset),
        .start      (start8),
        .dividend   (dividend8),
        .divisor    (divisor8),
        .busy       (busy8),
        .done       (done8),
        .quotient   (quot8),
        .remainder  (rem8),
        .div_by_zero(dbz8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sample(input int w, output logic dn, output logic bs,
                          output logic [7:0] q, output logic [7:0] r, output logic z);
        if (w == 4) begin
            dn = done4; bs = busy4; q = {4'b0, quot4}; r = {4'b0, rem4}; z = dbz4;
        end else begin
            dn = done8; bs = busy8; q = quot8; r = rem8; z = dbz8;
        end
    endtask

    // Start one operation and wait (bounded) for done; operands are scrambled after acceptance.
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic z,
                          output int lat, output int bcnt);
        logic dn;
        logic bs;
        @(posedge clock); #1;
        if (w == 4) begin
            start4 = 1'b1; dividend4 = a[3:0]; divisor4 = b[3:0];
        end else begin
            start8 = 1'b1; dividend8 = a; divisor8 = b;
        end
        @(posedge clock); #1;
        start4 = 1'b0; start8 = 1'b0;
        dividend4 = ~a[3:0]; divisor4 = ~b[3:0];
        dividend8 = ~a;      divisor8 = ~b;
        lat  = 1;
        bcnt = 0;
        sample(w, dn, bs, q, r, z);
        while (!dn && lat < 40) begin
            if (bs) bcnt++;
            @(posedge clock); #1;
            lat++;
            sample(w, dn, bs, q, r, z);
        end
    endtask

    task automatic check_op(input string name, input int w, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input logic ez);
        logic [7:0] q, r, q2, r2;
        logic       z, z2, dn, bs;
        int         lat, bcnt;
        run_op(w, a, b, q, r, z, lat, bcnt);
        check({name, " latency"}, lat, w + 1);
        check({name, " busy cycles"}, bcnt, w);
        check({name, " quotient"}, int'(q), int'(eq));
        check({name, " remainder"}, int'(r), int'(er));
        check({name, " div_by_zero"}, int'(z), int'(ez));
        @(posedge clock); #1;
        sample(w, dn, bs, q2, r2, z2);
        check({name, " done pulse width"}, int'(dn), 0);
        check({name, " quotient hold"}, int'(q2), int'(eq));
        check({name, " remainder hold"}, int'(r2), int'(er));
    endtask

    initial begin
        logic       dn, bs, z;
        logic [7:0] q, r;
        logic [7:0] ra, rb, mq, mr;
        int         lat;

        n_cmp = 0; n_fail = 0;
        reset = 1'b1;
        start4 = 1'b0; dividend4 = '0; divisor4 = '0;
        start8 = 1'b0; dividend8 = '0; divisor8 = '0;

        vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, z: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
        vecs[2] = '{a: 4'd0,  b: 4'd7,  q: 4'd0,  r: 4'd0, z: 1'b0};
        vecs[3] = '{a: 4'd7,  b: 4'd9,  q: 4'd0,  r: 4'd7, z: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
        vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, z: 1'b1};
        vecs[6] = '{a: 4'd11, b: 4'd2,  q: 4'd5,  r: 4'd1, z: 1'b0};

        @(posedge clock); @(posedge clock); #1;
        check("reset busy", int'(busy4), 0);
        check("reset done", int'(done4), 0);
        check("reset quotient", int'(quot4), 0);
        check("reset remainder", int'(rem4), 0);
        check("reset div_by_zero", int'(dbz4), 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++)
            check_op($sformatf("vec%0d", i), 4, {4'b0, vecs[i].a}, {4'b0, vecs[i].b},
                     {4'b0, vecs[i].q}, {4'b0, vecs[i].r}, vecs[i].z);

        // Re-pulsed start during RUN and DONE; start held from DONE into IDLE.
        @(posedge clock); #1;
        start4 = 1'b1; dividend4 = 4'd13; divisor4 = 4'd4;
        @(posedge clock); #1;
        start4 = 1'b0;
        @(posedge clock); #1;
        start4 = 1'b1; dividend4 = 4'd5; divisor4 = 4'd1;
        @(posedge clock); #1;
        start4 = 1'b0;
        lat = 3;
        while (!done4 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check("hs latency", lat, 5);
        check("hs quotient", int'(quot4), 3);
        check("hs remainder", int'(rem4), 1);
        start4 = 1'b1; dividend4 = 4'd2; divisor4 = 4'd1;
        @(posedge clock); #1;
        check("hs idle done", int'(done4), 0);
        check("hs idle busy", int'(busy4), 0);
        check("hs idle quotient", int'(quot4), 3);
        check("hs idle remainder", int'(rem4), 1);
        @(posedge clock); #1;
        start4 = 1'b0;
        check("hs held start busy", int'(busy4), 1);
        lat = 1;
        while (!done4 && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check("hs2 latency", lat, 5);
        check("hs2 quotient", int'(quot4), 2);
        check("hs2 remainder", int'(rem4), 0);

        // Asynchronous reset in the middle of a divide-by-zero operation.
        @(posedge clock); #1;
        start4 = 1'b1; dividend4 = 4'd9; divisor4 = 4'd0;
        @(posedge clock); #1;
        start4 = 1'b0;
        check("mid busy before reset", int'(busy4), 1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        #2;
        reset = 1'b1;
        #1;
        check("mid reset busy", int'(busy4), 0);
        check("mid reset done", int'(done4), 0);
        check("mid reset quotient", int'(quot4), 0);
        check("mid reset remainder", int'(rem4), 0);
        check("mid reset div_by_zero", int'(dbz4), 0);
        @(posedge clock); #1;
        check("mid reset held done", int'(done4), 0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (done4) check("mid reset stray done", 1, 0);
        end
        check_op("after reset 14/3", 4, 8'd14, 8'd3, 8'd4, 8'd2, 1'b0);

        // N=8 sweep against a reference model.
        check_op("n8 255/1", 8, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        check_op("n8 200/7", 8, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        check_op("n8 77/0", 8, 8'd77, 8'd0, 8'd255, 8'd77, 1'b1);
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (rb == 8'd0) begin
                mq = 8'd255; mr = ra;
            end else begin
                mq = ra / rb; mr = ra % rb;
            end
            check_op($sformatf("n8 %0d/%0d", ra, rb), 8, ra, rb, mq, mr, rb == 8'd0);
        end

        sample(4, dn, bs, q, r, z);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
